// File: rtl/data_memory_bytelane_if.sv
// Load/store bus between the MIPS datapath and the byte-lane data memory.
interface data_memory_bytelane_if;
    logic [31:0] Address;
    logic [31:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] Read_Data;
    logic        Read_Valid;
    logic        Mem_Ready;
    logic        Misaligned;

    modport master (
        output Address, Write_Data, MemRead, MemWrite, MemSize, MemUnsigned,
        input  Read_Data, Read_Valid, Mem_Ready, Misaligned
    );

    modport slave (
        input  Address, Write_Data, MemRead, MemWrite, MemSize, MemUnsigned,
        output Read_Data, Read_Valid, Mem_Ready, Misaligned
    );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory: per-lane stores, extended registered loads,
// misalignment rejection and an optional post-reset clear sweep.
module data_memory_bytelane #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input logic                   CLK,
    input logic                   RST,
    data_memory_bytelane_if.slave bus
);
    localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    read_valid_q, read_valid_d;
    logic                    misaligned_q, misaligned_d;
    logic                    mem_ready_q, mem_ready_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [3:0]              wr_be;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]              lane;
    logic                    aligned;
    logic [DATA_WIDTH-1:0]   cur_word;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [3:0]              st_be;
    logic [DATA_WIDTH-1:0]   st_data;
    logic                    unused_addr;

    assign unused_addr = ^bus.Address[31:ADDR_WIDTH+2];

    // Address decode, alignment check, load extraction and store lane steering
    always_comb begin
        word_idx = bus.Address[ADDR_WIDTH+1:2];
        lane     = bus.Address[1:0];
        cur_word = mem[word_idx];
        aligned  = 1'b0;
        load_val = cur_word;
        st_be    = 4'b0000;
        st_data  = bus.Write_Data;

        case (lane)
            2'd0:    ld_byte = cur_word[7:0];
            2'd1:    ld_byte = cur_word[15:8];
            2'd2:    ld_byte = cur_word[23:16];
            default: ld_byte = cur_word[31:24];
        endcase
        ld_half = lane[1] ? cur_word[31:16] : cur_word[15:0];

        case (bus.MemSize)
            2'b00: begin
                aligned  = 1'b1;
                load_val = bus.MemUnsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                st_be    = 4'b0001 << lane;
                st_data  = {4{bus.Write_Data[7:0]}};
            end
            2'b01: begin
                aligned  = ~lane[0];
                load_val = bus.MemUnsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
                st_be    = lane[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{bus.Write_Data[15:0]}};
            end
            2'b10: begin
                aligned  = (lane == 2'b00);
                st_be    = 4'b1111;
            end
            default: aligned = 1'b0;
        endcase
    end

    // Next-state, array write port selection and registered output values
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        misaligned_d = 1'b0;
        mem_ready_d  = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = word_idx;
        wr_be        = st_be;
        wr_data      = st_data;

        case (state_q)
            S_INIT: begin
                wr_en     = 1'b1;
                wr_idx    = clr_cnt_q;
                wr_be     = 4'b1111;
                wr_data   = '0;
                clr_cnt_d = ADDR_WIDTH'(clr_cnt_q + 1'b1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d     = S_IDLE;
                    mem_ready_d = 1'b1;
                end
            end
            default: begin
                mem_ready_d = 1'b1;
                // Ready is itself registered, so it also masks the first edge out of reset
                if (mem_ready_q && (bus.MemRead || bus.MemWrite)) begin
                    if (aligned) begin
                        wr_en        = bus.MemWrite;
                        read_valid_d = bus.MemRead;
                        if (bus.MemRead) read_data_d = load_val;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= INIT_CLEAR ? S_INIT : S_IDLE;
            clr_cnt_q    <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            mem_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
            mem_ready_q  <= mem_ready_d;
        end
    end

    // Array contents survive reset; only the clear sweep zeroes them
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) mem[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
            end
        end
    end

    assign bus.Read_Data  = read_data_q;
    assign bus.Read_Valid = read_valid_q;
    assign bus.Misaligned = misaligned_q;
    assign bus.Mem_Ready  = mem_ready_q;
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scenario bench for data_memory_bytelane with a load-result scoreboard.
module tb_data_memory_bytelane;
    logic CLK = 1'b0;
    logic RST;

    data_memory_bytelane_if bus ();

    data_memory_bytelane #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .INIT_CLEAR(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] sb [$];
    logic [31:0] mdl [32];

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.MemRead     = rd;
        bus.MemWrite    = wr;
        bus.MemSize     = sz;
        bus.MemUnsigned = uns;
        bus.Address     = a;
        bus.Write_Data  = wd;
    endtask

    task automatic idle();
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts edges after release until Mem_Ready; optionally holds a load request during INIT
    task automatic wait_ready(output int rise, output bit rv_seen, input int rd_from, input int rd_to);
        rise = 0;
        rv_seen = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            if (i == rd_from) drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
            if (i == rd_to) idle();
            tick();
            if (bus.Read_Valid === 1'b1) rv_seen = 1'b1;
            if (bus.Mem_Ready === 1'b1) begin
                rise = i;
                break;
            end
        end
        idle();
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] ln);
        logic [31:0] s;
        case (sz)
            2'b00: begin
                s = w >> (8 * ln);
                return uns ? (s & 32'h0000_00FF) : 32'($signed(s[7:0]));
            end
            2'b01: begin
                s = w >> (16 * ln[1]);
                return uns ? (s & 32'h0000_FFFF) : 32'($signed(s[15:0]));
            end
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] ln, input logic [31:0] wd);
        logic [31:0] m;
        logic [31:0] d;
        case (sz)
            2'b00:   begin m = 32'h0000_00FF << (8 * ln);     d = {4{wd[7:0]}};  end
            2'b01:   begin m = 32'h0000_FFFF << (16 * ln[1]); d = {2{wd[15:0]}}; end
            default: begin m = 32'hFFFF_FFFF;                 d = wd;            end
        endcase
        return (w & ~m) | (d & m);
    endfunction

    task automatic test_reset();
        logic [34:0] got;
        RST = 1'b1;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        #2 RST = 1'b0;
        #1;
        got = {bus.Mem_Ready, bus.Read_Valid, bus.Misaligned, bus.Read_Data};
        checks++;
        if (got !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", got, 35'h0);
        end
    endtask

    task automatic test_init();
        int rise;
        bit rv;
        logic [31:0] exp;
        logic [31:0] addrs [2] = '{32'h00, 32'h7C};
        @(negedge CLK);
        RST = 1'b1;
        wait_ready(rise, rv, 5, 10);
        checks++;
        if (rise != 32) begin
            errors++;
            $display("FAIL init_ready_edge: got %0d want 32", rise);
        end
        checks++;
        if (rv) begin
            errors++;
            $display("FAIL init_read_ignored: Read_Valid seen=1 want 0");
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 2'b10, 1'b0, addrs[i], 32'h0);
            sb.push_back(32'h0);
            tick();
            checks++;
            if (bus.Read_Valid !== 1'b1) begin
                errors++;
                $display("FAIL init_load_valid[%0d]: got %b want 1", i, bus.Read_Valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                if (bus.Read_Data !== exp) begin
                    errors++;
                    $display("FAIL init_load_data[%0d]: got %h want %h", i, bus.Read_Data, exp);
                end
            end
        end
        idle();
    endtask

    task automatic test_byte_loads();
        logic [31:0] exp;
        logic [31:0] addrs [5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13};
        logic        unss  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exps  [5] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0000_0080};
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 2'b00, unss[i], addrs[i], 32'h0);
            sb.push_back(exps[i]);
            tick();
            checks++;
            if (bus.Read_Valid !== 1'b1) begin
                errors++;
                $display("FAIL byte_load_valid[%0d]: got %b want 1", i, bus.Read_Valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                if (bus.Read_Data !== exp) begin
                    errors++;
                    $display("FAIL byte_load_data[%0d]: got %h want %h", i, bus.Read_Data, exp);
                end
            end
        end
        idle();
    endtask

    task automatic test_half_store();
        logic [31:0] exp;
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b01};
        logic [31:0] addrs [3] = '{32'h20, 32'h22, 32'h22};
        logic        unss  [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] exps  [3] = '{32'hBEEF_3344, 32'hFFFF_BEEF, 32'h0000_BEEF};
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        tick();
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, sizes[i], unss[i], addrs[i], 32'h0);
            sb.push_back(exps[i]);
            tick();
            checks++;
            if (bus.Read_Valid !== 1'b1) begin
                errors++;
                $display("FAIL half_load_valid[%0d]: got %b want 1", i, bus.Read_Valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                if (bus.Read_Data !== exp) begin
                    errors++;
                    $display("FAIL half_load_data[%0d]: got %h want %h", i, bus.Read_Data, exp);
                end
            end
        end
        idle();
    endtask

    task automatic test_misaligned();
        logic [34:0] got;
        logic [34:0] want;
        logic [31:0] exp;
        logic        rds   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b11};
        logic [31:0] addrs [4] = '{32'h05, 32'h03, 32'h10, 32'h10};
        logic [31:0] vaddr [3] = '{32'h04, 32'h00, 32'h10};
        logic [31:0] vexp  [3] = '{32'h0, 32'h0, 32'h80FF_7F01};
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            drive(rds[i], !rds[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF);
            tick();
            idle();
            got  = {bus.Misaligned, bus.Read_Valid, bus.Mem_Ready, bus.Read_Data};
            want = {1'b1, 1'b0, 1'b1, 32'hBEEF_3344};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL misaligned_pulse[%0d]: got %h want %h", i, got, want);
            end
            tick();
            checks++;
            if (bus.Misaligned !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_one_cycle[%0d]: got %b want 0", i, bus.Misaligned);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'b10, 1'b0, vaddr[i], 32'h0);
            sb.push_back(vexp[i]);
            tick();
            checks++;
            if (bus.Read_Valid !== 1'b1) begin
                errors++;
                $display("FAIL misaligned_target_valid[%0d]: got %b want 1", i, bus.Read_Valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                if (bus.Read_Data !== exp) begin
                    errors++;
                    $display("FAIL misaligned_target_data[%0d]: got %h want %h", i, bus.Read_Data, exp);
                end
            end
        end
        idle();
    endtask

    task automatic test_read_first();
        logic [31:0] exp;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'hAAAA_AAAA);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, (i == 0), 2'b10, 1'b0, 32'h08, 32'h5555_5555);
            sb.push_back(i == 0 ? 32'hAAAA_AAAA : 32'h5555_5555);
            tick();
            checks++;
            if (bus.Read_Valid !== 1'b1) begin
                errors++;
                $display("FAIL read_first_valid[%0d]: got %b want 1", i, bus.Read_Valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                if (bus.Read_Data !== exp) begin
                    errors++;
                    $display("FAIL read_first_data[%0d]: got %h want %h", i, bus.Read_Data, exp);
                end
            end
        end
        idle();
        tick();
        checks++;
        if (bus.Read_Valid !== 1'b0) begin
            errors++;
            $display("FAIL read_valid_drop: got %b want 0", bus.Read_Valid);
        end
    endtask

    task automatic test_back_to_back();
        logic        is_st;
        logic [1:0]  sz;
        logic [4:0]  idx;
        logic [1:0]  ln;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            mdl[i] = 32'(32'h9E37_79B9 * (i + 1)) | 32'h0100_0000;
            drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), mdl[i]);
            tick();
        end
        for (int i = 0; i < 48; i++) begin
            is_st = (i != 47) && ($urandom_range(0, 2) == 0);
            sz    = (i == 47) ? 2'b10 : 2'($urandom_range(0, 2));
            idx   = 5'($urandom_range(0, 31));
            ln    = 2'($urandom_range(0, 3));
            if (sz == 2'b01) ln[0] = 1'b0;
            if (sz == 2'b10) ln = 2'b00;
            uns   = 1'($urandom_range(0, 1));
            wd    = $urandom();
            drive(!is_st, is_st, sz, uns, {25'd0, idx, ln}, wd);
            if (is_st) mdl[idx] = model_store(mdl[idx], sz, ln, wd);
            else sb.push_back(model_load(mdl[idx], sz, uns, ln));
            tick();
            checks++;
            if (is_st) begin
                if (bus.Read_Valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_store_no_valid[%0d]: got %b want 0", i, bus.Read_Valid);
                end
            end else if (bus.Read_Valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_load_valid[%0d]: got %b want 1", i, bus.Read_Valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                if (bus.Read_Data !== exp) begin
                    errors++;
                    $display("FAIL b2b_load_data[%0d]: size %0d lane %0d got %h want %h", i, sz, ln, bus.Read_Data, exp);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_init();
        logic [34:0] got;
        logic [31:0] exp;
        int rise;
        bit rv;
        RST = 1'b0;
        #1;
        got = {bus.Mem_Ready, bus.Read_Valid, bus.Misaligned, bus.Read_Data};
        checks++;
        if (got !== 35'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h want %h", got, 35'h0);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (10) tick();
        RST = 1'b0;
        #1;
        got = {bus.Mem_Ready, bus.Read_Valid, bus.Misaligned, bus.Read_Data};
        checks++;
        if (got !== 35'h0) begin
            errors++;
            $display("FAIL mid_init_reset_outputs: got %h want %h", got, 35'h0);
        end
        @(negedge CLK);
        RST = 1'b1;
        wait_ready(rise, rv, 0, 0);
        checks++;
        if (rise != 32) begin
            errors++;
            $display("FAIL restart_ready_edge: got %0d want 32", rise);
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
            sb.push_back(32'h0);
            tick();
            checks++;
            if (bus.Read_Valid !== 1'b1) begin
                errors++;
                $display("FAIL cleared_valid[%0d]: got %b want 1", i, bus.Read_Valid);
                sb.delete();
            end else begin
                exp = sb.pop_front();
                if (bus.Read_Data !== exp) begin
                    errors++;
                    $display("FAIL cleared_word[%0d]: got %h want %h", i, bus.Read_Data, exp);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_loads();
        test_half_store();
        test_misaligned();
        test_read_first();
        test_back_to_back();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
